// File: rtl/fwd_pkg.sv
// Shared types and helpers for the hazard/forwarding controller: the shadow
// pipeline entry and the producer/consumer register match rule.
package fwd_pkg;

    localparam int REG_ADDR_W = 3;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic                  load;
        logic [REG_ADDR_W-1:0] dst;
    } hz_entry_t;

    // r0 is hardwired zero, so a write to it never produces a forwardable value
    function automatic logic entry_match(
        input hz_entry_t             e,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  use_src
    );
        return e.valid & e.wr & (e.dst != REG_ZERO) & (e.dst == src) & use_src;
    endfunction

endpackage

// File: rtl/fwd_compare.sv
// Per-operand comparator: decides which in-flight producer (if any) feeds one
// source operand, and whether that producer is a load still in EX.
module fwd_compare
    import fwd_pkg::*;
(
    input  hz_entry_t             ex,
    input  hz_entry_t             mem,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    output logic                  hit_one,
    output logic                  hit_two,
    output logic                  load_hit
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = entry_match(ex, src, use_src);
    assign mem_match = entry_match(mem, src, use_src);

    // The younger producer in EX shadows any older write in MEM
    assign hit_one  = ex_match;
    assign hit_two  = ~ex_match & mem_match;
    assign load_hit = ex_match & ex.load;

endmodule

// File: rtl/forwarding_ctrl.sv
// Hazard detection and operand-forwarding control beside the ID/EX register.
// Selects are registered so they line up with the consumer's EX cycle.
module forwarding_ctrl #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src_a,
    input  logic [REG_ADDR_W-1:0] id_src_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wr,
    input  logic                  id_load,
    output logic                  one_A,
    output logic                  one_B,
    output logic                  two_A,
    output logic                  two_B,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);
    import fwd_pkg::*;

    hz_entry_t        ex_q, ex_d;
    hz_entry_t        mem_q, mem_d;
    logic             one_a_q, one_a_d, one_b_q, one_b_d;
    logic             two_a_q, two_a_d, two_b_q, two_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hit_one_a, hit_two_a, load_hit_a;
    logic hit_one_b, hit_two_b, load_hit_b;
    logic issue;

    fwd_compare u_cmp_a (
        .ex       (ex_q),
        .mem      (mem_q),
        .src      (id_src_a),
        .use_src  (id_use_a),
        .hit_one  (hit_one_a),
        .hit_two  (hit_two_a),
        .load_hit (load_hit_a)
    );

    fwd_compare u_cmp_b (
        .ex       (ex_q),
        .mem      (mem_q),
        .src      (id_src_b),
        .use_src  (id_use_b),
        .hit_one  (hit_one_b),
        .hit_two  (hit_two_b),
        .load_hit (load_hit_b)
    );

    // Driven from the (possibly frozen) state even while hold is asserted
    assign stall = id_valid & (load_hit_a | load_hit_b);
    assign issue = id_valid & ~stall;

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        one_a_d = one_a_q;
        one_b_d = one_b_q;
        two_a_d = two_a_q;
        two_b_d = two_b_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            if (flush) begin
                ex_d    = '0;
                mem_d   = '0;
                one_a_d = 1'b0;
                one_b_d = 1'b0;
                two_a_d = 1'b0;
                two_b_d = 1'b0;
            end else begin
                mem_d   = ex_q;
                ex_d    = '{valid: issue, wr: id_wr, load: id_load, dst: id_dst};
                one_a_d = issue & hit_one_a;
                one_b_d = issue & hit_one_b;
                two_a_d = issue & hit_two_a;
                two_b_d = issue & hit_two_b;
                if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            one_a_q <= 1'b0;
            one_b_q <= 1'b0;
            two_a_q <= 1'b0;
            two_b_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            one_a_q <= one_a_d;
            one_b_q <= one_b_d;
            two_a_q <= two_a_d;
            two_b_q <= two_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign one_A       = one_a_q;
    assign one_B       = one_b_q;
    assign two_A       = two_a_q;
    assign two_B       = two_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Directed-vector bench for forwarding_ctrl: forwarding distances, load-use
// stall, r0/unused sources, flush, hold and asynchronous reset.
module tb_forwarding_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_src_a = '0;
    logic [2:0]  id_src_b = '0;
    logic        id_use_a = 1'b0;
    logic        id_use_b = 1'b0;
    logic [2:0]  id_dst = '0;
    logic        id_wr = 1'b0;
    logic        id_load = 1'b0;
    logic        one_A, one_B, two_A, two_B, stall;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    forwarding_ctrl #(.REG_ADDR_W(3), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_src_a    (id_src_a),
        .id_src_b    (id_src_b),
        .id_use_a    (id_use_a),
        .id_use_b    (id_use_b),
        .id_dst      (id_dst),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .one_A       (one_A),
        .one_B       (one_B),
        .two_A       (two_A),
        .two_B       (two_B),
        .stall       (stall),
        .stall_count (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sel(input string tag, input logic a1, input logic b1, input logic a2, input logic b2);
        check({tag, ".one_A"}, 32'(one_A), 32'(a1));
        check({tag, ".one_B"}, 32'(one_B), 32'(b1));
        check({tag, ".two_A"}, 32'(two_A), 32'(a2));
        check({tag, ".two_B"}, 32'(two_B), 32'(b2));
    endtask

    task automatic drive(input logic v, input logic [2:0] sa, input logic ua,
                         input logic [2:0] sb, input logic ub,
                         input logic [2:0] d, input logic w, input logic ld);
        id_valid = v;  id_src_a = sa; id_use_a = ua;
        id_src_b = sb; id_use_b = ub;
        id_dst = d;    id_wr = w;     id_load = ld;
        $display("t=%0t ID v=%0b a=r%0d/%0b b=r%0d/%0b dst=r%0d wr=%0b ld=%0b hold=%0b flush=%0b",
                 $time, v, sa, ua, sb, ub, d, w, ld, hold, flush);
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop(); tick();
        nop(); tick();
    endtask

    initial begin
        // Reset state
        #7;
        sel("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.count", 32'(stall_count), 32'd0);
        rst = 1'b0;
        tick();

        // Distance 1: add r3, then consumer reading r3 on A
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 3'd6, 1'b1, 1'b0); #1;
        check("d1.stall", 32'(stall), 32'd0);
        tick();
        sel("d1", 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Distance 2: write r3, NOP, consumer reading r3 on B
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0); tick();
        nop(); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 1'b0); tick();
        sel("d2", 1'b0, 1'b0, 1'b0, 1'b1);

        // Two writers of r3: the newest one wins
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 1'b0); tick();
        sel("newest", 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Load-use: load r5, then consumer of r5 on A
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b1); tick();
        drive(1'b1, 3'd5, 1'b1, 3'd2, 1'b1, 3'd7, 1'b1, 1'b0); #1;
        check("lu.stall", 32'(stall), 32'd1);
        check("lu.count0", 32'(stall_count), 32'd0);
        tick();
        check("lu.count1", 32'(stall_count), 32'd1);
        check("lu.restall", 32'(stall), 32'd0);
        sel("lu.bubble", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        sel("lu.fwd", 1'b0, 1'b0, 1'b1, 1'b0);
        check("lu.count_once", 32'(stall_count), 32'd1);
        drain();

        // Load, unrelated instruction, then consumer: no stall
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b1); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0); #1;
        check("gap.stall0", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 3'd5, 1'b1, 3'd2, 1'b1, 3'd7, 1'b1, 1'b0); #1;
        check("gap.stall1", 32'(stall), 32'd0);
        tick();
        sel("gap", 1'b0, 1'b0, 1'b1, 1'b0);
        check("gap.count", 32'(stall_count), 32'd1);
        drain();

        // r0 destination never forwards
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0); tick();
        sel("r0", 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Unused source B matching the producer does not forward
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd4, 1'b1, 3'd4, 1'b0, 3'd6, 1'b1, 1'b0); tick();
        sel("unused", 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Flush kills a pending forward and empties both entries
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0); tick();
        flush = 1'b1;
        drive(1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0); tick();
        flush = 1'b0;
        sel("flush.fwd", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0); tick();
        sel("flush.mem", 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Flush during a load-use stall: stall clears, count unchanged
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b1); tick();
        drive(1'b1, 3'd5, 1'b1, 3'd2, 1'b1, 3'd7, 1'b1, 1'b0); #1;
        check("fst.stall", 32'(stall), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nop(); #1;
        check("fst.stall_after", 32'(stall), 32'd0);
        sel("fst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("fst.count", 32'(stall_count), 32'd1);
        drain();

        // Hold for 3 cycles while a load-use stall is pending
        drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd1, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b1); tick();
        sel("prehold", 1'b1, 1'b0, 1'b0, 1'b0);
        hold = 1'b1;
        drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1, 1'b0); #1;
        check("hold.stall", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            sel("hold", 1'b1, 1'b0, 1'b0, 1'b0);
            check("hold.stall_i", 32'(stall), 32'd1);
            check("hold.count", 32'(stall_count), 32'd1);
        end
        hold = 1'b0;
        tick();
        check("unhold.count", 32'(stall_count), 32'd2);
        check("unhold.stall", 32'(stall), 32'd0);
        sel("unhold", 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of a stall, between clock edges
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0); tick();
        drive(1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 1'b1); tick();
        sel("prerst", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1, 1'b0); #1;
        check("prerst.stall", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst.stall", 32'(stall), 32'd0);
        check("arst.count", 32'(stall_count), 32'd0);
        sel("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        nop();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
